// File: rtl/multiplicador.sv
// Sequential unsigned shift-and-add multiplier with a valid/done/ack handshake.
// One multiplier bit is consumed per clock; the product is published only on completion.
module multiplicador #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 valid_data,
  input  logic                 ack,
  output logic [2*WIDTH-1:0]   producto,
  output logic                 Done_Flag
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [PW-1:0]     a_reg, a_d;
  logic [WIDTH-1:0]  b_reg, b_d;
  logic [PW-1:0]     acc, acc_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [PW-1:0]     prod_d;
  logic              done_d;
  logic [PW-1:0]     sum;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      cnt       <= '0;
      producto  <= '0;
      Done_Flag <= 1'b0;
    end else begin
      state     <= state_d;
      a_reg     <= a_d;
      b_reg     <= b_d;
      acc       <= acc_d;
      cnt       <= cnt_d;
      producto  <= prod_d;
      Done_Flag <= done_d;
    end
  end

  // Next-state and next-datapath logic; the last step's add goes straight into producto
  always_comb begin
    state_d = state;
    a_d     = a_reg;
    b_d     = b_reg;
    acc_d   = acc;
    cnt_d   = cnt;
    prod_d  = producto;
    done_d  = Done_Flag;
    sum     = acc + (b_reg[0] ? a_reg : PW'(0));

    unique case (state)
      IDLE: begin
        done_d = 1'b0;
        if (valid_data) begin
          a_d     = PW'(a);
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = sum;
        a_d   = a_reg << 1;
        b_d   = b_reg >> 1;
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          prod_d  = sum;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d = 1'b1;
        if (ack) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multiplicador.sv
// Randomized and directed bench for multiplicador against a plain-arithmetic product model.
module tb_multiplicador;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LAT   = WIDTH + 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 valid_data;
  logic                 ack;
  logic [2*WIDTH-1:0]   producto;
  logic                 Done_Flag;

  int tests_run    = 0;
  int tests_failed = 0;

  multiplicador #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .valid_data (valid_data),
    .ack        (ack),
    .producto   (producto),
    .Done_Flag  (Done_Flag)
  );

  always #5 clk = ~clk;

  function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return 64'(x) * 64'(y);
  endfunction

  // Present operands, scramble inputs while busy, report edges-to-done and the result
  task automatic start_and_wait(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                input logic keep, output int lat, output logic [2*WIDTH-1:0] prod);
    a = x; b = y; valid_data = 1'b1;
    lat = 0; prod = '0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (Done_Flag) begin
        lat = n; prod = producto;
        break;
      end
      a = $urandom; b = $urandom;
      if (!keep) valid_data = 1'($urandom % 2);
    end
    valid_data = keep;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_data = 1'b1; ack = 1'b0; a = '1; b = '1;
    repeat (3) @(posedge clk);
    #1;
    valid_data = 1'b0;
    tests_run++;
    if (Done_Flag !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", Done_Flag); end
    tests_run++;
    if (producto !== 64'd0) begin tests_failed++; $display("FAIL reset_prod got=%h exp=0", producto); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Run one multiplication and check latency, product, ack release and retention
  task automatic check_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input string nm);
    int lat;
    logic [2*WIDTH-1:0] prod, exp_p;
    exp_p = model(x, y);
    start_and_wait(x, y, 1'b0, lat, prod);
    tests_run++;
    if (lat != LAT) begin tests_failed++; $display("FAIL %s_latency got=%0d exp=%0d", nm, lat, LAT); end
    tests_run++;
    if (prod !== exp_p) begin tests_failed++; $display("FAIL %s_prod a=%h b=%h got=%h exp=%h", nm, x, y, prod, exp_p); end
    do_ack();
    tests_run++;
    if (Done_Flag !== 1'b0) begin tests_failed++; $display("FAIL %s_ack_release got=%b exp=0", nm, Done_Flag); end
    tests_run++;
    if (producto !== exp_p) begin tests_failed++; $display("FAIL %s_retain got=%h exp=%h", nm, producto, exp_p); end
  endtask

  task automatic test_directed();
    check_op(32'hFFFFFFFF, 32'hFFFFFFFF, "max");
    tests_run++;
    if (model(32'hFFFFFFFF, 32'hFFFFFFFF) !== 64'hFFFFFFFE00000001 || producto !== 64'hFFFFFFFE00000001) begin
      tests_failed++; $display("FAIL max_const got=%h exp=fffffffe00000001", producto);
    end
    check_op(32'd3, 32'd5, "three_five");
    check_op(32'd0, 32'h12345678, "zero_a");
    check_op(32'd1, 32'hFFFFFFFF, "one_max");
    check_op(32'h80000000, 32'd2, "msb_two");
    check_op(32'hDEADBEEF, 32'd0, "zero_b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      logic [WIDTH-1:0] x, y;
      x = $urandom; y = $urandom;
      if (i == 0) x = 32'h1;
      if (i == 1) y = 32'h80000000;
      check_op(x, y, "rand");
    end
  endtask

  // Result must hold steady while ack stays low; partial sums never appear on producto
  task automatic test_hold();
    int lat, bad;
    logic [2*WIDTH-1:0] prod, exp_p, prev;
    logic [WIDTH-1:0] x, y;
    x = $urandom; y = $urandom;
    exp_p = model(x, y);
    prev = producto;
    a = x; b = y; valid_data = 1'b1;
    @(posedge clk); #1;
    valid_data = 1'b0;
    bad = 0;
    for (int n = 0; n < int'(WIDTH) - 1; n++) begin
      a = $urandom; b = $urandom; valid_data = 1'($urandom % 2); ack = 1'($urandom % 2);
      @(posedge clk); #1;
      if (producto !== prev || Done_Flag !== 1'b0) bad++;
    end
    valid_data = 1'b0; ack = 1'b0;
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL busy_no_partial bad_cycles=%0d exp=0", bad); end
    @(posedge clk); #1;
    prod = producto; lat = Done_Flag ? 1 : 0;
    tests_run++;
    if (lat != 1 || prod !== exp_p) begin tests_failed++; $display("FAIL hold_first done=%0d got=%h exp=%h", lat, prod, exp_p); end
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      valid_data = 1'($urandom % 2); a = $urandom; b = $urandom;
      @(posedge clk); #1;
      if (Done_Flag !== 1'b1 || producto !== exp_p) bad++;
    end
    valid_data = 1'b0;
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL hold_20 bad_cycles=%0d exp=0", bad); end
    do_ack();
    tests_run++;
    if (Done_Flag !== 1'b0) begin tests_failed++; $display("FAIL hold_ack got=%b exp=0", Done_Flag); end
  endtask

  // Reset mid-operation aborts; nothing completes until a fresh request
  task automatic test_reset_busy();
    int seen, lat;
    logic [2*WIDTH-1:0] prod;
    a = $urandom; b = $urandom; valid_data = 1'b1;
    @(posedge clk); #1;
    valid_data = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests_run++;
    if (Done_Flag !== 1'b0) begin tests_failed++; $display("FAIL rst_busy_done got=%b exp=0", Done_Flag); end
    tests_run++;
    if (producto !== 64'd0) begin tests_failed++; $display("FAIL rst_busy_prod got=%h exp=0", producto); end
    seen = 0;
    for (int n = 0; n < 50; n++) begin
      ack = 1'($urandom % 2);
      @(posedge clk); #1;
      if (Done_Flag) seen++;
    end
    ack = 1'b0;
    tests_run++;
    if (seen != 0) begin tests_failed++; $display("FAIL rst_busy_spurious done_cycles=%0d exp=0", seen); end
    start_and_wait(32'd7, 32'd9, 1'b0, lat, prod);
    tests_run++;
    if (lat != LAT || prod !== 64'd63) begin tests_failed++; $display("FAIL rst_busy_fresh lat=%0d got=%h exp=%0d/3f", lat, prod, LAT); end
    do_ack();
  endtask

  // valid_data held through ack launches a second operation immediately
  task automatic test_back_to_back();
    int lat, lat2;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] x1, y1, x2, y2;
    x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
    start_and_wait(x1, y1, 1'b1, lat, prod);
    tests_run++;
    if (lat != LAT || prod !== model(x1, y1)) begin tests_failed++; $display("FAIL b2b_first lat=%0d got=%h exp=%h", lat, prod, model(x1, y1)); end
    a = x2; b = y2;
    do_ack();
    lat2 = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (Done_Flag) begin lat2 = n; break; end
    end
    valid_data = 1'b0;
    tests_run++;
    if (lat2 != LAT) begin tests_failed++; $display("FAIL b2b_latency got=%0d exp=%0d", lat2, LAT); end
    tests_run++;
    if (producto !== model(x2, y2)) begin tests_failed++; $display("FAIL b2b_second got=%h exp=%h", producto, model(x2, y2)); end
    do_ack();
    @(posedge clk); #1;
    tests_run++;
    if (Done_Flag !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle got=%b exp=0", Done_Flag); end
  endtask

  initial begin
    reset = 1'b1; valid_data = 1'b0; ack = 1'b0; a = '0; b = '0;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
